rv_rr_arbiter: RTL and testbench
================================

Name: rv_rr_arbiter

Overview:
Round-robin arbiter that merges NUM_REQ ready/valid byte streams onto one ready/valid output stream. The output passes through a registered stage. A source that wins arbitration keeps the grant for a bounded burst of beats. It sits in front of any single-consumer ready/valid sink (`out_*` side) that several producers (`in_*` side) must share. Each output beat is tagged with the index of the source it came from.

Parameters:
- NUM_REQ, 4, number of requesting input streams; legal range 2..16.
- DATA_WIDTH, 8, payload width per stream.
- MAX_BURST, 4, maximum consecutive beats granted to one source before rotation; 1 gives pure per-beat round-robin.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  NUM_REQ*DATA_WIDTH  packed payloads; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  NUM_REQ  per-source valid.
- in_ready  output  NUM_REQ  per-source ready; at most one bit set per cycle.
- out_data  output  DATA_WIDTH  registered payload.
- out_src  output  SRC_W  registered index of the source of out_data; SRC_W = max(1, clog2(NUM_REQ)).
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, state=IDLE, ptr=0, owner=0, burst_cnt=0.
- While rst_n is low, in_ready=0. Asserting reset mid-operation drops any buffered beat. No output beat is produced after reset release until a new input handshake occurs.
- load_en = !out_valid | out_ready. The output register can accept a beat in the same cycle it presents one: full throughput, 1 beat/cycle.
- sel is computed combinationally.
- in_ready[i] = load_en & any_req & (sel == i). No in_ready bit is asserted unless the selected source has in_valid high.
- A transfer occurs when in_valid[sel] & in_ready[sel]. On the next edge: out_data <= in_data[sel], out_src <= sel, out_valid <= 1.
- Latency: 1 cycle from input handshake to out_valid.
- If load_en and no transfer: out_valid <= 0.
- If !load_en (stall): out_data, out_src and out_valid hold. Arbitration state is frozen.
- States:
  - IDLE: sel = first i with in_valid[i], searching ptr, ptr+1, ..., wrapping mod NUM_REQ.
    - Transfer with MAX_BURST==1 → stay IDLE, ptr <= sel+1 mod NUM_REQ.
    - Transfer with MAX_BURST>1 → LOCKED, owner <= sel, burst_cnt <= 1.
  - LOCKED: if in_valid[owner], sel = owner.
    - On transfer, burst_cnt increments.
    - When a transfer makes burst_cnt reach MAX_BURST → IDLE, ptr <= owner+1, burst_cnt <= 0.
  - LOCKED with owner not valid while load_en: lock releases that cycle.
    - sel uses the IDLE search from owner+1, and a transfer may occur in the same cycle.
    - Next state follows the IDLE transfer rules; if no transfer, → IDLE with ptr <= owner+1.
  - LOCKED with owner not valid under stall: no change.
- Wrap-around: ptr and owner+1 wrap modulo NUM_REQ. With non-power-of-2 NUM_REQ, index NUM_REQ-1 wraps to 0.
- burst_cnt width = clog2(MAX_BURST+1). It never exceeds MAX_BURST.
- in_valid may drop without a handshake; the arbiter treats the source as not requesting and raises no protocol error.
- Only the in_data of the selected source is sampled.

Decomposition:
- Package rv_arb_pkg: typedef enum {ARB_IDLE, ARB_LOCKED} arb_state_t; function src_width(n) returning max(1, clog2(n)).
- One natural sub-module, rr_pick (combinational):
  - Inputs: req[NUM_REQ], ptr.
  - Outputs: any, idx.
  - Finds the first set bit at or after ptr with wrap, via a doubled-vector search.
- Top level holds the FSM, burst counter and output register.

Test Plan:
1. Reset mid-stream, with out_valid=1 and out_ready=0 → out_valid=0 asynchronously, all in_ready=0. After release, the first grant goes to the lowest valid index at or after 0.
2. MAX_BURST=1, all four sources valid continuously, out_ready=1 → out_src sequence 0,1,2,3,0,1,… One beat every cycle. out_data matches each source's counter payload (0x10+n, 0x20+n, 0x30+n, 0x40+n).
3. MAX_BURST=4, sources 1 and 3 valid, out_ready=1 → out_src 1,1,1,1,3,3,3,3,1,… Never more than 4 consecutive beats from one source.
4. MAX_BURST=4, source 2 locked, valid drops after 2 beats while source 0 valid → in_ready[0] asserts in the same cycle 2 drops. Next out_src=0; no idle bubble.
5. Backpressure: out_ready=0 for 3 cycles with out_valid=1, data 0xA5 from source 1 → out_data/out_src/out_valid held. in_ready=0 throughout. On out_ready=1, 0xA5 is accepted and the next beat loads in the same cycle.
6. NUM_REQ=3, only source 2 valid, then only source 0 → grant wraps 2→0. ptr never reaches 3; out_src stays within 0..2.

Source files
------------

// File: rtl/rv_arb_pkg.sv
// Shared types and helpers for the round-robin ready/valid arbiter.
package rv_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic int src_width(input int n);
    if (n < 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Wrap-around first-set search: lowest requesting index at or after ptr.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] idx
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  logic [PW-1:0]  off_s;
  logic [PW:0]    sum_s;

  assign any = |req;

  // Rotate the doubled request vector so ptr lands at bit 0, then priority-encode.
  always_comb begin
    dbl_s = {req, req};
    rot_s = '0;
    for (int i = 0; i < N; i++) begin
      rot_s[i] = dbl_s[32'(ptr) + i];
    end
    off_s = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = PW'(i);
      end else begin
        off_s = off_s;
      end
    end
    sum_s = {1'b0, ptr} + {1'b0, off_s};
    if (sum_s >= (PW+1)'(N)) begin
      idx = PW'(sum_s - (PW+1)'(N));
    end else begin
      idx = sum_s[PW-1:0];
    end
  end

endmodule

// File: rtl/rv_rr_arbiter.sv
// Round-robin merge of NUM_REQ ready/valid byte streams with burst lock and
// a registered output stage tagged with the source index.
module rv_rr_arbiter
  import rv_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int SRC_W      = src_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_valid,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]              out_src,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t            state_r;
  logic [SRC_W-1:0]      ptr_r;
  logic [SRC_W-1:0]      owner_r;
  logic [BW-1:0]         burst_cnt_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [SRC_W-1:0]      out_src_r;
  logic                  out_valid_r;

  logic                  load_en_s;
  logic                  owner_hold_s;
  logic [SRC_W-1:0]      owner_next_s;
  logic [SRC_W-1:0]      pick_ptr_s;
  logic [SRC_W-1:0]      pick_idx_s;
  logic                  pick_any_s;
  logic [SRC_W-1:0]      sel_s;
  logic                  xfer_s;
  logic [DATA_WIDTH-1:0] sel_data_s;

  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] v);
    if (v == SRC_W'(NUM_REQ - 1)) begin
      return '0;
    end else begin
      return v + SRC_W'(1);
    end
  endfunction

  rr_pick #(
    .N  (NUM_REQ),
    .PW (SRC_W)
  ) u_pick (
    .req (in_valid),
    .ptr (pick_ptr_s),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  // Selection and handshake: a released lock searches onward from owner+1.
  always_comb begin
    load_en_s    = ~out_valid_r | out_ready;
    owner_next_s = wrap_inc(owner_r);
    if (state_r == ARB_LOCKED) begin
      owner_hold_s = in_valid[owner_r];
      pick_ptr_s   = owner_next_s;
    end else begin
      owner_hold_s = 1'b0;
      pick_ptr_s   = ptr_r;
    end
    sel_s      = owner_hold_s ? owner_r : pick_idx_s;
    xfer_s     = load_en_s & pick_any_s & rst_n;
    sel_data_s = in_data[sel_s*DATA_WIDTH +: DATA_WIDTH];
    in_ready   = '0;
    if (xfer_s) begin
      in_ready[sel_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Output register, arbitration FSM and burst counter; all frozen on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ARB_IDLE;
      ptr_r       <= '0;
      owner_r     <= '0;
      burst_cnt_r <= '0;
      out_data_r  <= '0;
      out_src_r   <= '0;
      out_valid_r <= 1'b0;
    end else if (load_en_s) begin
      out_valid_r <= xfer_s;
      if (xfer_s) begin
        out_data_r <= sel_data_s;
        out_src_r  <= sel_s;
      end
      case (state_r)
        ARB_IDLE: begin
          if (xfer_s) begin
            if (MAX_BURST == 1) begin
              ptr_r <= wrap_inc(sel_s);
            end else begin
              state_r     <= ARB_LOCKED;
              owner_r     <= sel_s;
              burst_cnt_r <= BW'(1);
            end
          end
        end
        ARB_LOCKED: begin
          if (owner_hold_s) begin
            if (burst_cnt_r + BW'(1) == BW'(MAX_BURST)) begin
              state_r     <= ARB_IDLE;
              ptr_r       <= owner_next_s;
              burst_cnt_r <= '0;
            end else begin
              burst_cnt_r <= burst_cnt_r + BW'(1);
            end
          end else if (xfer_s) begin
            if (MAX_BURST == 1) begin
              state_r     <= ARB_IDLE;
              ptr_r       <= wrap_inc(sel_s);
              burst_cnt_r <= '0;
            end else begin
              owner_r     <= sel_s;
              burst_cnt_r <= BW'(1);
            end
          end else begin
            state_r     <= ARB_IDLE;
            ptr_r       <= owner_next_s;
            burst_cnt_r <= '0;
          end
        end
        default: begin
          state_r     <= ARB_IDLE;
          ptr_r       <= '0;
          burst_cnt_r <= '0;
        end
      endcase
    end
  end

  assign out_data  = out_data_r;
  assign out_src   = out_src_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// Randomized lockstep bench: a 4-source/burst-4 and a 3-source/burst-1 arbiter
// against a queue-free behavioural model of the arbitration rules.
module tb_rv_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] a_in_data;
  logic [3:0]  a_in_valid, a_in_ready;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_src;
  logic        a_out_valid, a_out_ready;
  logic [23:0] b_in_data;
  logic [2:0]  b_in_valid, b_in_ready;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_src;
  logic        b_out_valid, b_out_ready;

  rv_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_src(a_out_src),
    .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  rv_rr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_src(b_out_src),
    .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int nreq[2]   = '{4, 3};
  int mburst[2] = '{4, 1};
  int m_ptr[2], m_owner[2], m_cnt[2], m_od[2], m_os[2];
  bit m_locked[2], m_ov[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      m_ptr[u] = 0; m_owner[u] = 0; m_cnt[u] = 0;
      m_od[u] = 0; m_os[u] = 0; m_locked[u] = 1'b0; m_ov[u] = 1'b0;
    end
  endfunction

  function automatic int model_sel(input int u, input logic [3:0] v);
    int start;
    if (m_locked[u] && v[m_owner[u]]) return m_owner[u];
    start = m_locked[u] ? (m_owner[u] + 1) % nreq[u] : m_ptr[u];
    for (int k = 0; k < nreq[u]; k++) begin
      if (v[(start + k) % nreq[u]]) return (start + k) % nreq[u];
    end
    return -1;
  endfunction

  task automatic model_step(input int u, input logic [3:0] v, input logic [31:0] d,
                            input logic ordy, output logic [3:0] exp_rdy);
    int  s;
    bit  load, xfer;
    exp_rdy = 4'b0000;
    load = !m_ov[u] || ordy;
    s    = model_sel(u, v);
    xfer = load && (s >= 0);
    if (xfer) exp_rdy[s] = 1'b1;
    if (load) begin
      m_ov[u] = xfer;
      if (xfer) begin
        m_od[u] = (d >> (8 * s)) & 255;
        m_os[u] = s;
      end
      if (m_locked[u] && v[m_owner[u]]) begin
        m_cnt[u]++;
        if (m_cnt[u] == mburst[u]) begin
          m_locked[u] = 1'b0;
          m_ptr[u]    = (m_owner[u] + 1) % nreq[u];
          m_cnt[u]    = 0;
        end
      end else if (xfer) begin
        if (mburst[u] == 1) begin
          m_locked[u] = 1'b0;
          m_ptr[u]    = (s + 1) % nreq[u];
        end else begin
          m_locked[u] = 1'b1;
          m_owner[u]  = s;
          m_cnt[u]    = 1;
        end
      end else if (m_locked[u]) begin
        m_locked[u] = 1'b0;
        m_ptr[u]    = (m_owner[u] + 1) % nreq[u];
        m_cnt[u]    = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("a_out_valid", a_out_valid, m_ov[0]);
    check_eq("a_out_data",  a_out_data,  m_od[0]);
    check_eq("a_out_src",   a_out_src,   m_os[0]);
    check_eq("b_out_valid", b_out_valid, m_ov[1]);
    check_eq("b_out_data",  b_out_data,  m_od[1]);
    check_eq("b_out_src",   b_out_src,   m_os[1]);
  endtask

  // mode 0: all valid, counter payloads; 1: random; 2: sources 1,3 / 2;
  // 3: lock then drop; 4: random with heavy backpressure; 5: all valid, stalled
  task automatic drive(input int mode);
    int ph;
    ph = cyc % 6;
    for (int i = 0; i < 4; i++) begin
      a_in_data[8*i +: 8] = (mode == 0) ? 8'(32'h10 * (i + 1) + cyc) : 8'($urandom);
    end
    for (int i = 0; i < 3; i++) begin
      b_in_data[8*i +: 8] = (mode == 0) ? 8'(32'h10 * (i + 1) + cyc) : 8'($urandom);
    end
    case (mode)
      0: begin a_in_valid = 4'hF; b_in_valid = 3'h7; end
      2: begin a_in_valid = 4'b1010; b_in_valid = 3'b100; end
      3: begin a_in_valid = (ph < 2) ? 4'b0100 : 4'b0001; b_in_valid = 3'b001; end
      5: begin a_in_valid = 4'hF; b_in_valid = 3'h7; end
      default: begin
        for (int i = 0; i < 4; i++) a_in_valid[i] = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 3; i++) b_in_valid[i] = ($urandom_range(0, 3) != 0);
      end
    endcase
    case (mode)
      1: begin a_out_ready = ($urandom_range(0, 3) != 0); b_out_ready = ($urandom_range(0, 3) != 0); end
      4: begin a_out_ready = ($urandom_range(0, 2) == 0); b_out_ready = ($urandom_range(0, 2) == 0); end
      5: begin a_out_ready = 1'b0; b_out_ready = 1'b0; end
      default: begin a_out_ready = 1'b1; b_out_ready = 1'b1; end
    endcase
  endtask

  task automatic run_cycle(input int mode);
    logic [3:0] er;
    @(negedge clk);
    cyc++;
    check_outputs();
    drive(mode);
    #1;
    model_step(0, a_in_valid, a_in_data, a_out_ready, er);
    check_eq("a_in_ready", a_in_ready, er);
    model_step(1, {1'b0, b_in_valid}, {8'h00, b_in_data}, b_out_ready, er);
    check_eq("b_in_ready", b_in_ready, {1'b0, er[2:0]});
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_eq("a_in_ready_rst", a_in_ready, 32'h0);
    check_eq("b_in_ready_rst", b_in_ready, 32'h0);
    @(negedge clk);
    a_in_valid = 4'hF; b_in_valid = 3'h7; a_out_ready = 1'b1; b_out_ready = 1'b1;
    #1;
    check_eq("a_in_ready_rst_vld", a_in_ready, 32'h0);
    check_eq("b_in_ready_rst_vld", b_in_ready, 32'h0);
    @(negedge clk);
    a_in_valid = 4'h0; b_in_valid = 3'h0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_data = '0; a_in_valid = '0; a_out_ready = 1'b0;
    b_in_data = '0; b_in_valid = '0; b_out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    check_eq("a_in_ready_init", a_in_ready, 32'h0);
    rst_n = 1'b1;

    repeat (20)  run_cycle(0);
    repeat (24)  run_cycle(2);
    repeat (24)  run_cycle(3);
    repeat (300) run_cycle(1);
    repeat (4)   run_cycle(5);
    mid_reset();
    repeat (6)   run_cycle(0);
    repeat (300) run_cycle(4);
    repeat (100) run_cycle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
